unified_mem_arbiter: RTL
========================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 3: consecutive contested DM grants before IF is forced to win.
REQ-002 SHALL have parameter MAX_WAIT, default 15: number of BUSY cycles before a timeout. Used only with ARB_TIMEOUT_EN.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  instruction-fetch request.
- if_addr  in  32  fetch word address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data-port request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data word address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data.
- mem_en  out  1  shared memory access strobe.
- mem_we  out  1  shared memory write enable.
- mem_addr  out  32  shared memory address.
- mem_wdata  out  32  shared memory write data.
- mem_rdata  in  32  shared memory read data.
- mem_ready  in  1  memory completion, sampled while mem_en=1.
- stall_if  out  1  combinational: if_req & ~if_ack.
- stall_mem  out  1  combinational: dm_req & ~dm_ack.
- err  out  1  access ended by timeout; valid with the ack pulse.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-005 In IDLE, a valid request SHALL move the FSM to BUSY_IF or BUSY_DM on the next edge. On that edge, SHALL register mem_en=1 and mem_addr, mem_we and mem_wdata from the winning port.
REQ-006 For the IF port, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-007 On contention (both requests valid), DM SHALL win unless starve_cnt equals STARVE_LIM, in which case IF SHALL win.
REQ-008 starve_cnt SHALL increment on each DM grant made while if_req=1, saturating at STARVE_LIM. It SHALL clear on any IF grant.
REQ-009 In a BUSY state, mem_en, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ready=1 is sampled.
REQ-010 On sampling mem_ready=1 in BUSY_x, on the next edge the FSM SHALL:
- return to IDLE;
- set mem_en=0 and mem_we=0;
- pulse the matching ack for exactly one cycle.
REQ-011 For a read, the matching rdata SHALL capture mem_rdata on that same edge.
REQ-012 For a store, dm_rdata SHALL hold its previous value.
REQ-013 Minimum latency: request sampled at edge N, mem_en high after edge N, mem_ready high in that cycle, ack high after edge N+1 (two cycles request-to-ack).
REQ-014 In the cycle its ack is high, a port's req SHALL NOT be considered for arbitration. A new request from that port is honoured from the following cycle.
REQ-015 The other port's request in the ack cycle SHALL be arbitrated normally. Back-to-back alternating grants are therefore possible.
REQ-016 if_ack and dm_ack SHALL never be high in the same cycle.
REQ-017 At most one access SHALL be outstanding at any time.
REQ-018 mem_ready sampled while in IDLE SHALL be ignored.
REQ-019 A requester dropping req in a BUSY state SHALL NOT abort the access. The ack is still issued.

Reset
REQ-020 rst=0 sampled at an edge SHALL force, on that edge:
- state IDLE;
- starve_cnt and the wait counter to 0;
- mem_en, mem_we, if_ack, dm_ack and err to 0;
- mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-021 Reset asserted during BUSY SHALL abandon the access with no ack. mem_en SHALL be low in the cycle after the reset edge.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined, a wait counter SHALL count BUSY cycles.
REQ-023 With ARB_TIMEOUT_EN defined, if MAX_WAIT BUSY cycles elapse without mem_ready, on the next edge the block SHALL:
- go to IDLE;
- drop mem_en;
- pulse the matching ack with err=1 and rdata=0.
REQ-024 Without ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely, err SHALL be tied to 0, and no wait counter SHALL exist.

Verification
REQ-025 Single IF read: if_req=1, if_addr=0x10, mem_ready=1 immediately, mem_rdata=0x8C010004 -> mem_en high for 1 cycle, mem_addr=0x10, if_ack pulse 2 cycles after the request, if_rdata=0x8C010004.
REQ-026 Contention: both requests held continuously, mem_ready always 1, STARVE_LIM=3 -> grant order DM,DM,DM,IF,DM,DM,DM,IF; no cycle with both acks high.
REQ-027 Store: dm_req=1, dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we=1 and fields stable 4 cycles, dm_ack once, dm_rdata unchanged.
REQ-028 Reset mid-access: rst=0 on the 2nd BUSY cycle of a DM load -> no dm_ack, mem_en=0 and all outputs 0 after the edge, the next request is served normally.
REQ-029 Timeout (ARB_TIMEOUT_EN, MAX_WAIT=15): IF read, mem_ready held 0 -> if_ack with err=1 and if_rdata=0 after 15 BUSY cycles. Without the macro: no ack after 100 cycles, err=0.
REQ-030 Stall outputs: dm_req raised during an IF access with mem_ready after 2 cycles -> stall_mem=1 until dm_ack; stall_if=0 in the if_ack cycle.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: requester ports (IF, DM) and the shared memory port of the arbiter.
// The arbiter takes the slave modport; the environment driving requests and memory takes master.
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one shared memory port for IF and DM; DM wins contention unless IF has lost STARVE_LIM times.
// Optional macro ARB_TIMEOUT_EN ends an access after MAX_WAIT BUSY cycles with err=1.
module unified_mem_arbiter #(
    parameter int STARVE_LIM = 3,
    parameter int MAX_WAIT   = 15
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    state_t        state, next;
    logic [SW-1:0] starve_cnt;
    logic          if_v, dm_v, busy, pick_if, pick_dm, fin, tmo;

    // A port is deaf to its own req during its ack cycle.
    assign if_v = bus.if_req & ~bus.if_ack;
    assign dm_v = bus.dm_req & ~bus.dm_ack;
    assign busy = state != IDLE;

    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

    logic [WW-1:0] wait_cnt;

    assign tmo = busy & ~bus.mem_ready & (wait_cnt == WLAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
            bus.err  <= 1'b0;
        end else begin
            wait_cnt <= (busy & ~fin) ? wait_cnt + WW'(1) : '0;
            bus.err  <= tmo;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = busy ? (fin ? IDLE : state) : (pick_if ? BUSY_IF : pick_dm ? BUSY_DM : IDLE);
    end

    always_comb begin
        pick_if = ~busy & if_v & (~dm_v | (starve_cnt == LIM));
        pick_dm = ~busy & dm_v & ~pick_if;
        fin     = busy & (bus.mem_ready | tmo);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt    <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_ack <= fin & (state == BUSY_IF);
            bus.dm_ack <= fin & (state == BUSY_DM);
            if (pick_if | pick_dm) begin
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= pick_dm & bus.dm_we;
                bus.mem_addr  <= pick_if ? bus.if_addr : bus.dm_addr;
                bus.mem_wdata <= pick_if ? 32'd0 : bus.dm_wdata;
            end else if (fin) begin
                bus.mem_en <= 1'b0;
                bus.mem_we <= 1'b0;
            end
            if (fin & (state == BUSY_IF))
                bus.if_rdata <= tmo ? 32'd0 : bus.mem_rdata;
            if (fin & (state == BUSY_DM) & (tmo | ~bus.mem_we))
                bus.dm_rdata <= tmo ? 32'd0 : bus.mem_rdata;
            if (pick_if)
                starve_cnt <= '0;
            else if (pick_dm & bus.if_req & (starve_cnt != LIM))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule
